// File: rtl/spi_slave_rx.sv
// SPI mode-3 slave receiver: oversamples sclk/cs_n/mosi in the clk domain, shifts one
// DATA_W-bit word per frame MSB first, hands it off on valid/ready and returns tx_data on miso.
module spi_slave_rx #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ovr,
    output logic              frame_err,
    output logic              busy,
    output logic [4:0]        bit_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_e;

    state_e              state_q;
    logic [SYNC_STG-1:0] sclk_sync_q;
    logic [SYNC_STG-1:0] cs_sync_q;
    logic [SYNC_STG-1:0] mosi_sync_q;
    logic                sclk_prev_q;
    logic                cs_prev_q;
    logic [DATA_W-1:0]   rx_shift_q;
    logic [DATA_W-1:0]   tx_shift_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                rx_ovr_q;
    logic                frame_err_q;
    logic                miso_oe_q;
    logic [4:0]          bit_cnt_q;

    logic                sclk_s;
    logic                cs_s;
    logic                mosi_s;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_rise;
    logic                cs_fall;
    logic [DATA_W-1:0]   rx_shift_d;
    logic [4:0]          bit_cnt_d;

    assign sclk_s     = sclk_sync_q[SYNC_STG-1];
    assign cs_s       = cs_sync_q[SYNC_STG-1];
    assign mosi_s     = mosi_sync_q[SYNC_STG-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign cs_fall    = ~cs_s & cs_prev_q;
    assign rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
    assign bit_cnt_d  = bit_cnt_q + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            miso_oe_q   <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;

            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift_q <= tx_data;
                        bit_cnt_q  <= '0;
                        miso_oe_q  <= 1'b1;
                        state_q    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        miso_oe_q   <= 1'b0;
                        tx_shift_q  <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_d;
                        if (bit_cnt_d == 5'(DATA_W)) begin
                            // A word accepted this same cycle frees the slot, so no overrun.
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= rx_shift_d;
                                rx_valid_q <= 1'b1;
                            end else begin
                                rx_ovr_q <= 1'b1;
                            end
                            state_q <= HOLD;
                        end
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        // The leading fall launches the MSB already on miso; later falls shift.
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        miso_oe_q  <= 1'b0;
                        tx_shift_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso      = tx_shift_q[DATA_W-1];
    assign miso_oe   = miso_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_ovr    = rx_ovr_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: the bench acts as a mode-3 SPI master with an 8-clk sclk period.
module tb_spi_slave_rx;

    logic        clk;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_ovr;
    logic        frame_err;
    logic        busy;
    logic [4:0]  bit_cnt;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned ovr_cnt;
    int unsigned ferr_cnt;
    int unsigned lat;
    int unsigned snap_ovr;
    int unsigned snap_ferr;
    logic [15:0] miso_word;

    spi_slave_rx #(
        .DATA_W   (16),
        .SYNC_STG (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_ovr    (rx_ovr),
        .frame_err (frame_err),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles-high counters, so a one-cycle pulse adds exactly one.
    initial begin
        ovr_cnt  = 0;
        ferr_cnt = 0;
    end
    always @(negedge clk) begin
        if (rx_ovr)    ovr_cnt  = ovr_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Shifts nbits of data (MSB first) with 4-clk low/high phases; optionally pulses
    // rx_ready for exactly the cycle in which the last rise is acted on.
    task automatic frame_bits(input logic [31:0] data, input int nbits, input bit ready_pulse);
        logic [31:0] d;
        d = data;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = d[nbits-1-i];
            repeat (4) @(negedge clk);
            if (i < 16) miso_word = {miso_word[14:0], miso};
            sclk = 1'b1;
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                if (i == 15 && lat == 0 && rx_valid) lat = j;
                if (ready_pulse && i == nbits - 1 && j == 2) rx_ready = 1'b1;
                if (ready_pulse && i == nbits - 1 && j == 3) rx_ready = 1'b0;
            end
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        miso_word = '0;
        reset     = 1'b0;
        sclk      = 1'b1;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        rx_ready  = 1'b0;
        tx_data   = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_rx_data", 32'(rx_data), 32'h0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_miso_oe", 32'(miso_oe), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        check_eq("rst_miso", 32'(miso), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // T1 basic frame, tx_data changed after the frame has started
        tx_data = 16'h3C5A;
        cs_start();
        tx_data = 16'hFFFF;
        check_eq("t1_busy", 32'(busy), 32'h1);
        check_eq("t1_miso_oe", 32'(miso_oe), 32'h1);
        frame_bits(32'h0000A5C3, 16, 1'b0);
        check_eq("t1_latency", 32'(lat), 32'd3);
        check_eq("t1_rx_data", 32'(rx_data), 32'hA5C3);
        check_eq("t1_rx_valid", 32'(rx_valid), 32'h1);
        check_eq("t1_miso_word", 32'(miso_word), 32'h3C5A);
        check_eq("t1_bit_cnt", 32'(bit_cnt), 32'd16);
        cs_end();
        check_eq("t1_idle_oe", 32'(miso_oe), 32'h0);
        check_eq("t1_idle_miso", 32'(miso), 32'h0);
        check_eq("t1_idle_busy", 32'(busy), 32'h0);
        consume();
        check_eq("t1_consumed", 32'(rx_valid), 32'h0);

        // T2 back-pressure overrun
        snap_ovr = ovr_cnt;
        cs_start();
        frame_bits(32'h00001234, 16, 1'b0);
        cs_end();
        check_eq("t2_no_ovr_first", 32'(ovr_cnt - snap_ovr), 32'd0);
        cs_start();
        frame_bits(32'h0000BEEF, 16, 1'b0);
        cs_end();
        check_eq("t2_ovr_pulses", 32'(ovr_cnt - snap_ovr), 32'd1);
        check_eq("t2_rx_data", 32'(rx_data), 32'h1234);
        check_eq("t2_rx_valid", 32'(rx_valid), 32'h1);
        consume();
        check_eq("t2_consumed", 32'(rx_valid), 32'h0);

        // T3 short frame
        snap_ferr = ferr_cnt;
        cs_start();
        frame_bits(32'h000001AB, 9, 1'b0);
        check_eq("t3_bit_cnt_mid", 32'(bit_cnt), 32'd9);
        cs_end();
        check_eq("t3_frame_err", 32'(ferr_cnt - snap_ferr), 32'd1);
        check_eq("t3_rx_valid", 32'(rx_valid), 32'h0);
        check_eq("t3_rx_data", 32'(rx_data), 32'h1234);
        check_eq("t3_busy", 32'(busy), 32'h0);
        check_eq("t3_bit_cnt", 32'(bit_cnt), 32'd0);

        // T4 over-length frame saturates in HOLD
        snap_ovr  = ovr_cnt;
        snap_ferr = ferr_cnt;
        cs_start();
        frame_bits(32'h000FFFF0, 20, 1'b0);
        check_eq("t4_bit_cnt_hold", 32'(bit_cnt), 32'd16);
        check_eq("t4_busy", 32'(busy), 32'h1);
        check_eq("t4_rx_data", 32'(rx_data), 32'hFFFF);
        check_eq("t4_rx_valid", 32'(rx_valid), 32'h1);
        cs_end();
        check_eq("t4_bit_cnt_idle", 32'(bit_cnt), 32'd0);
        check_eq("t4_no_ovr", 32'(ovr_cnt - snap_ovr), 32'd0);
        check_eq("t4_no_ferr", 32'(ferr_cnt - snap_ferr), 32'd0);
        consume();

        // T5 asynchronous reset mid-frame
        snap_ferr = ferr_cnt;
        cs_start();
        frame_bits(32'h000000FF, 5, 1'b0);
        check_eq("t5_bit_cnt_pre", 32'(bit_cnt), 32'd5);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_busy", 32'(busy), 32'h0);
        check_eq("t5_bit_cnt", 32'(bit_cnt), 32'd0);
        check_eq("t5_miso_oe", 32'(miso_oe), 32'h0);
        check_eq("t5_rx_data", 32'(rx_data), 32'h0);
        cs_n = 1'b1;
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t5_no_ferr", 32'(ferr_cnt - snap_ferr), 32'd0);
        cs_start();
        frame_bits(32'h000000FF, 16, 1'b0);
        cs_end();
        check_eq("t5_rx_data_new", 32'(rx_data), 32'h00FF);
        check_eq("t5_rx_valid", 32'(rx_valid), 32'h1);
        consume();

        // T6 completion coincides with acceptance of the previous word
        snap_ovr = ovr_cnt;
        cs_start();
        frame_bits(32'h00005A5A, 16, 1'b0);
        cs_end();
        cs_start();
        frame_bits(32'h0000C3C3, 16, 1'b1);
        cs_end();
        check_eq("t6_no_ovr", 32'(ovr_cnt - snap_ovr), 32'd0);
        check_eq("t6_rx_valid", 32'(rx_valid), 32'h1);
        check_eq("t6_rx_data", 32'(rx_data), 32'hC3C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
